// File: rtl/multireg_bank.sv
// multireg_bank
//   A bank of CHANNELS registers, each BUSWIDTH bits wide. Every channel
//   is visible on a flat parallel bus.
//
//   The bank has four parts:
//   - A write port. It writes one selected channel, or all channels when
//     wr_bcast is set.
//   - A readback port with one cycle of latency.
//   - Per-channel dirty flags.
//   - A dump engine. It snapshots every channel and streams the snapshot
//     out one channel per beat over a valid/ready interface.
//
// Ports
//   clk, reset      clock; asynchronous active-high reset of all state
//   wr_en           write strobe
//   wr_bcast        with wr_en, write wr_data to every channel
//   wr_chan         target channel of a single write (out of range: ignored)
//   wr_data         write data
//   outlines        flat register contents, channel i at [i*BUSWIDTH +: BUSWIDTH]
//   rd_chan         readback select
//   rd_data         registered readback (0 for out-of-range select)
//   dirty           bit i set when channel i was written since the last dump start
//   dump_start      snapshot-and-stream request (honoured only when idle)
//   dump_busy       high while a dump is streaming
//   dump_valid      dump beat valid
//   dump_ready      consumer accepts the beat when high together with dump_valid
//   dump_data       snapshot value of dump_chan
//   dump_chan       channel index of the current beat
//   dump_last       current beat is channel CHANNELS-1
module multireg_bank #(
    parameter int                    BUSWIDTH    = 8,
    parameter int                    CHANNELS    = 4,
    parameter int                    CHANNELBITS = 2,
    parameter logic [BUSWIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         wr_bcast,
    input  logic [CHANNELBITS-1:0]       wr_chan,
    input  logic [BUSWIDTH-1:0]          wr_data,
    output logic [CHANNELS*BUSWIDTH-1:0] outlines,
    input  logic [CHANNELBITS-1:0]       rd_chan,
    output logic [BUSWIDTH-1:0]          rd_data,
    output logic [CHANNELS-1:0]          dirty,
    input  logic                         dump_start,
    output logic                         dump_busy,
    output logic                         dump_valid,
    input  logic                         dump_ready,
    output logic [BUSWIDTH-1:0]          dump_data,
    output logic [CHANNELBITS-1:0]       dump_chan,
    output logic                         dump_last
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [CHANNELBITS-1:0] LAST_IDX = CHANNELBITS'(CHANNELS - 1);

    state_t                 state;
    state_t                 state_next;
    logic [BUSWIDTH-1:0]    regs   [CHANNELS];
    logic [BUSWIDTH-1:0]    shadow [CHANNELS];
    logic [CHANNELBITS-1:0] index;
    logic [CHANNELS-1:0]    dirty_q;
    logic [CHANNELS-1:0]    wr_hit;
    logic [BUSWIDTH-1:0]    rd_mux;
    logic [BUSWIDTH-1:0]    dump_mux;
    logic                   streaming;
    logic                   at_last;
    logic                   handshake;
    logic                   dump_accept;

    // Decode by comparing against each channel number instead of indexing.
    // An out-of-range wr_chan/rd_chan then matches nothing: the write is
    // dropped and the read returns 0.
    always_comb begin
        wr_hit   = '0;
        rd_mux   = '0;
        dump_mux = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && (wr_bcast || (32'(wr_chan) == i))) wr_hit[i] = 1'b1;
            if (32'(rd_chan) == i) rd_mux   = regs[i];
            if (32'(index) == i)   dump_mux = shadow[i];
        end
    end

    always_comb begin
        streaming   = (state == STREAM);
        at_last     = streaming && (index == LAST_IDX);
        handshake   = streaming && dump_ready;
        dump_accept = (state == IDLE) && dump_start;

        state_next = state;
        case (state)
            IDLE:    if (dump_start) state_next = STREAM;
            STREAM:  if (handshake && at_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Dump outputs derive from the registered state only. An
        // asynchronous reset therefore drops them at once, and they hold
        // steady while the consumer stalls.
        dump_valid = streaming;
        dump_busy  = streaming;
        dump_last  = at_last;
        dump_chan  = streaming ? index : '0;
        dump_data  = streaming ? dump_mux : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                regs[i]   <= RESET_VALUE;
                shadow[i] <= '0;
            end
            index   <= '0;
            dirty_q <= '0;
            rd_data <= RESET_VALUE;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_hit[i]) regs[i] <= wr_data;
            end
            // Readback samples the pre-write contents, so a same-edge write
            // shows up on the following cycle.
            rd_data <= rd_mux;
            if (dump_accept) begin
                for (int i = 0; i < CHANNELS; i++) shadow[i] <= regs[i];
                index <= '0;
            end else if (handshake && !at_last) begin
                index <= index + CHANNELBITS'(1);
            end
            // A write on the dump-start edge lands after the clear, so its
            // dirty bit survives.
            dirty_q <= (dump_accept ? '0 : dirty_q) | wr_hit;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign outlines[g*BUSWIDTH +: BUSWIDTH] = regs[g];
    end

    assign dirty = dirty_q;

endmodule

// File: tb/tb_multireg_bank.sv
// tb_multireg_bank
//   Drives a 4-channel and a 3-channel multireg_bank. Stimulus is applied on
//   the falling edge and outputs are compared on the following falling edge.
//   The bench uses directed vector tables, hand sequences for dumps and
//   reset, and a randomized run against a queue-based reference model.
module tb_multireg_bank;
    localparam int BW = 8;
    localparam int CH = 4;
    localparam int CB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              wr_en, wr_bcast, dump_start, dump_ready;
    logic [CB-1:0]     wr_chan, rd_chan;
    logic [BW-1:0]     wr_data;
    logic [CH*BW-1:0]  outlines;
    logic [BW-1:0]     rd_data, dump_data;
    logic [CH-1:0]     dirty;
    logic              dump_busy, dump_valid, dump_last;
    logic [CB-1:0]     dump_chan;

    logic              s3_wr_en, s3_wr_bcast, s3_dump_start, s3_dump_ready;
    logic [CB-1:0]     s3_wr_chan, s3_rd_chan;
    logic [BW-1:0]     s3_wr_data;
    logic [3*BW-1:0]   s3_outlines;
    logic [BW-1:0]     s3_rd_data, s3_dump_data;
    logic [2:0]        s3_dirty;
    logic              s3_dump_busy, s3_dump_valid, s3_dump_last;
    logic [CB-1:0]     s3_dump_chan;

    multireg_bank #(.BUSWIDTH(BW), .CHANNELS(CH), .CHANNELBITS(CB)) u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_bcast(wr_bcast),
        .wr_chan(wr_chan), .wr_data(wr_data), .outlines(outlines),
        .rd_chan(rd_chan), .rd_data(rd_data), .dirty(dirty),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_data(dump_data), .dump_chan(dump_chan),
        .dump_last(dump_last)
    );

    multireg_bank #(.BUSWIDTH(BW), .CHANNELS(3), .CHANNELBITS(CB)) u_dut3 (
        .clk(clk), .reset(reset), .wr_en(s3_wr_en), .wr_bcast(s3_wr_bcast),
        .wr_chan(s3_wr_chan), .wr_data(s3_wr_data), .outlines(s3_outlines),
        .rd_chan(s3_rd_chan), .rd_data(s3_rd_data), .dirty(s3_dirty),
        .dump_start(s3_dump_start), .dump_busy(s3_dump_busy),
        .dump_valid(s3_dump_valid), .dump_ready(s3_dump_ready),
        .dump_data(s3_dump_data), .dump_chan(s3_dump_chan),
        .dump_last(s3_dump_last)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic check_beat(input string tag, input logic v, input int c,
                              input logic [BW-1:0] d, input logic l);
        check({tag, ".valid"}, 64'(dump_valid), 64'(v));
        check({tag, ".busy"},  64'(dump_busy),  64'(v));
        if (v) begin
            check({tag, ".chan"}, 64'(dump_chan), 64'(c));
            check({tag, ".data"}, 64'(dump_data), 64'(d));
            check({tag, ".last"}, 64'(dump_last), 64'(l));
        end
    endtask

    task automatic check_beat3(input string tag, input logic v, input int c,
                               input logic [BW-1:0] d, input logic l);
        check({tag, ".valid"}, 64'(s3_dump_valid), 64'(v));
        check({tag, ".busy"},  64'(s3_dump_busy),  64'(v));
        if (v) begin
            check({tag, ".chan"}, 64'(s3_dump_chan), 64'(c));
            check({tag, ".data"}, 64'(s3_dump_data), 64'(d));
            check({tag, ".last"}, 64'(s3_dump_last), 64'(l));
        end
    endtask

    // Directed write/readback vectors: expectations after the edge.
    typedef struct {
        logic        we;
        logic        bc;
        logic [1:0]  ch;
        logic [7:0]  data;
        logic [1:0]  rd;
        logic [31:0] out;
        logic [3:0]  dty;
        logic [7:0]  rdd;
    } vec_t;
    vec_t tbl[9];

    // Reference model: contents, dirty flags, readback and a queue of the
    // snapshot beats still to be delivered.
    logic [BW-1:0] m_regs[CH];
    logic [CH-1:0] m_dirty;
    logic [BW-1:0] m_rd;
    logic [BW-1:0] m_q[$];

    task automatic model_reset();
        for (int i = 0; i < CH; i++) m_regs[i] = '0;
        m_dirty = '0;
        m_rd    = '0;
        m_q.delete();
    endtask

    task automatic model_step();
        m_rd = (int'(rd_chan) < CH) ? m_regs[rd_chan] : '0;
        if (m_q.size() > 0) begin
            if (dump_ready) void'(m_q.pop_front());
        end else if (dump_start) begin
            for (int i = 0; i < CH; i++) m_q.push_back(m_regs[i]);
            m_dirty = '0;
        end
        if (wr_en) begin
            if (wr_bcast) begin
                for (int i = 0; i < CH; i++) m_regs[i] = wr_data;
                m_dirty = '1;
            end else if (int'(wr_chan) < CH) begin
                m_regs[wr_chan]  = wr_data;
                m_dirty[wr_chan] = 1'b1;
            end
        end
    endtask

    task automatic model_compare(input int cyc);
        logic [CH*BW-1:0] exp_out;
        for (int i = 0; i < CH; i++) exp_out[i*BW +: BW] = m_regs[i];
        check($sformatf("rnd%0d.outlines", cyc), 64'(outlines), 64'(exp_out));
        check($sformatf("rnd%0d.dirty", cyc),    64'(dirty),    64'(m_dirty));
        check($sformatf("rnd%0d.rd_data", cyc),  64'(rd_data),  64'(m_rd));
        check_beat($sformatf("rnd%0d", cyc), m_q.size() > 0, CH - m_q.size(),
                   (m_q.size() > 0) ? m_q[0] : 8'h00, m_q.size() == 1);
    endtask

    initial begin
        logic ready_pat[6];
        int   beat_pat[6];

        reset = 1'b1;
        wr_en = 0; wr_bcast = 0; wr_chan = 0; wr_data = 0; rd_chan = 0;
        dump_start = 0; dump_ready = 0;
        s3_wr_en = 0; s3_wr_bcast = 0; s3_wr_chan = 0; s3_wr_data = 0;
        s3_rd_chan = 0; s3_dump_start = 0; s3_dump_ready = 0;

        tbl[0] = '{1'b1, 1'b0, 2'd2, 8'hA5, 2'd2, 32'h00A50000, 4'b0100, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 32'h00A50000, 4'b0100, 8'hA5};
        tbl[2] = '{1'b1, 1'b1, 2'd1, 8'h3C, 2'd0, 32'h3C3C3C3C, 4'b1111, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 2'd1, 8'h11, 2'd1, 32'h3C3C113C, 4'b1111, 8'h3C};
        tbl[4] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 32'h3C3C113C, 4'b1111, 8'h11};
        tbl[5] = '{1'b1, 1'b0, 2'd0, 8'h01, 2'd3, 32'h3C3C1101, 4'b1111, 8'h3C};
        tbl[6] = '{1'b1, 1'b0, 2'd1, 8'h02, 2'd0, 32'h3C3C0201, 4'b1111, 8'h01};
        tbl[7] = '{1'b1, 1'b0, 2'd2, 8'h03, 2'd2, 32'h3C030201, 4'b1111, 8'h3C};
        tbl[8] = '{1'b1, 1'b0, 2'd3, 8'h04, 2'd2, 32'h04030201, 4'b1111, 8'h03};

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset.outlines", 64'(outlines), 64'h0);
        check("reset.dirty",    64'(dirty),    64'h0);
        check("reset.rd_data",  64'(rd_data),  64'h0);
        check("reset.last",     64'(dump_last), 64'h0);
        check("reset.dump_data", 64'(dump_data), 64'h0);
        check("reset.dump_chan", 64'(dump_chan), 64'h0);
        check_beat("reset", 1'b0, 0, 8'h00, 1'b0);

        // Directed writes / broadcast / readback latency
        for (int i = 0; i < 9; i++) begin
            wr_en = tbl[i].we; wr_bcast = tbl[i].bc; wr_chan = tbl[i].ch;
            wr_data = tbl[i].data; rd_chan = tbl[i].rd;
            @(negedge clk);
            check($sformatf("vec%0d.outlines", i), 64'(outlines), 64'(tbl[i].out));
            check($sformatf("vec%0d.dirty", i),    64'(dirty),    64'(tbl[i].dty));
            check($sformatf("vec%0d.rd_data", i),  64'(rd_data),  64'(tbl[i].rdd));
        end
        wr_en = 0; wr_bcast = 0;

        // Full-rate dump of 01..04
        dump_ready = 1; dump_start = 1;
        @(negedge clk);
        dump_start = 0;
        check("dump1.dirty", 64'(dirty), 64'h0);
        for (int b = 0; b < CH; b++) begin
            check_beat($sformatf("dump1.b%0d", b), 1'b1, b, 8'(b + 1), b == CH - 1);
            @(negedge clk);
        end
        check_beat("dump1.end", 1'b0, 0, 8'h00, 1'b0);
        check("dump1.end_dirty", 64'(dirty), 64'h0);

        // Back-pressured dump with a write to ch3 mid-stream
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        beat_pat  = '{0, 1, 1, 1, 2, 3};
        dump_start = 1;
        @(negedge clk);
        dump_start = 0;
        for (int k = 0; k < 6; k++) begin
            dump_ready = ready_pat[k];
            wr_en = (k == 1); wr_chan = 2'd3; wr_data = 8'hFF;
            check_beat($sformatf("dump2.k%0d", k), 1'b1, beat_pat[k],
                       8'(beat_pat[k] + 1), beat_pat[k] == CH - 1);
            @(negedge clk);
        end
        wr_en = 0;
        check_beat("dump2.end", 1'b0, 0, 8'h00, 1'b0);
        check("dump2.ch3_live", 64'(outlines[31:24]), 64'hFF);
        check("dump2.dirty", 64'(dirty), 64'h8);

        // Asynchronous reset during the second beat
        dump_ready = 1; dump_start = 1;
        @(negedge clk);
        dump_start = 0;
        check_beat("dump3.b0", 1'b1, 0, 8'h01, 1'b0);
        @(negedge clk);
        check_beat("dump3.b1", 1'b1, 1, 8'h02, 1'b0);
        reset = 1'b1;
        #1;
        check_beat("dump3.async", 1'b0, 0, 8'h00, 1'b0);
        check("dump3.outlines", 64'(outlines), 64'h0);
        check("dump3.dirty", 64'(dirty), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        dump_start = 1;
        @(negedge clk);
        dump_start = 0;
        for (int b = 0; b < CH; b++) begin
            check_beat($sformatf("dump4.b%0d", b), 1'b1, b, 8'h00, b == CH - 1);
            @(negedge clk);
        end
        check_beat("dump4.end", 1'b0, 0, 8'h00, 1'b0);

        // Three-channel instance: out-of-range write/read, 3-beat dump
        s3_wr_en = 1; s3_wr_chan = 2'd1; s3_wr_data = 8'h5A;
        @(negedge clk);
        check("c3.outlines", 64'(s3_outlines), 64'h005A00);
        check("c3.dirty", 64'(s3_dirty), 64'h2);
        s3_wr_chan = 2'd3; s3_wr_data = 8'h77; s3_rd_chan = 2'd3;
        @(negedge clk);
        s3_wr_en = 0;
        check("c3.oob_outlines", 64'(s3_outlines), 64'h005A00);
        check("c3.oob_dirty", 64'(s3_dirty), 64'h2);
        check("c3.oob_rd", 64'(s3_rd_data), 64'h0);
        s3_dump_ready = 1; s3_dump_start = 1;
        @(negedge clk);
        s3_dump_start = 0;
        check_beat3("c3.b0", 1'b1, 0, 8'h00, 1'b0);
        @(negedge clk);
        check_beat3("c3.b1", 1'b1, 1, 8'h5A, 1'b0);
        @(negedge clk);
        check_beat3("c3.b2", 1'b1, 2, 8'h00, 1'b1);
        @(negedge clk);
        check_beat3("c3.end", 1'b0, 0, 8'h00, 1'b0);

        // Randomized run against the reference model
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            model_compare(c);
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_bcast   = ($urandom_range(0, 5) == 0);
            wr_chan    = 2'($urandom);
            wr_data    = 8'($urandom);
            rd_chan    = 2'($urandom);
            dump_start = ($urandom_range(0, 7) == 0);
            dump_ready = ($urandom_range(0, 3) != 0);
            model_step();
            @(negedge clk);
        end
        model_compare(400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
